acc_dump_ctrl: RTL and testbench
================================

ACC_DUMP_CTRL -- requirements
Module: acc_dump_ctrl
Sits between the sample source and the accumulator stage. It gates and clears the accumulator, counts samples per integration, and dumps each integrated result into an output buffer.

Interface
REQ-001 SHALL have parameter INPUT_DATA_WIDTH, default 32: width of the accumulator result.
REQ-002 SHALL have parameter ACC_LEN_WIDTH, default 16: width of the integration-length input.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: number of output buffer entries (power of two, at least 2).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  when high, integrations run; when low, the block parks in IDLE after the current dump.
REQ-007 acc_len  in  ACC_LEN_WIDTH  samples per integration; 0 is treated as 1.
REQ-008 in_valid  in  1  sample present upstream.
REQ-009 in_ready  out  1  sample accepted when in_valid && in_ready.
REQ-010 acc_en  out  1  enable to the accumulator stage.
REQ-011 acc_clr  out  1  active-high clear to the accumulator; only meaningful when acc_en is high.
REQ-012 acc_data  in  INPUT_DATA_WIDTH  registered accumulator result.
REQ-013 out_data  out  INPUT_DATA_WIDTH  dumped integration result.
REQ-014 out_seq  out  16  integration sequence number; wraps 0xFFFF to 0.
REQ-015 out_valid  out  1  output word present.
REQ-016 out_ready  in  1  output consumed when out_valid && out_ready.

Function
REQ-017 FSM states SHALL be IDLE, CLEAR, RUN, DUMP.
REQ-018 IDLE: in_ready=0, acc_en=0; go to CLEAR when enable=1.
REQ-019 CLEAR (one cycle): acc_en=1, acc_clr=1, in_ready=0; latch acc_len (0 becomes 1) into len_q; sample count=0; go to RUN.
REQ-020 RUN: in_ready=1, acc_en=in_valid, acc_clr=0; each accepted sample increments the count; the accepted sample that makes count equal len_q moves the FSM to DUMP.
REQ-021 DUMP: in_ready=0, acc_en=0; if the buffer is not full, write {acc_data, seq}, increment seq, then go to CLEAR if enable=1, else IDLE; if the buffer is full, stay in DUMP with no data loss.
REQ-022 The dump SHALL capture acc_data exactly one cycle after the last sample is accepted, i.e. after the accumulator's registered update.
REQ-023 Minimum integration period SHALL be len_q+2 cycles with continuous in_valid and out_ready.
REQ-024 A change of acc_len during RUN SHALL take effect only at the next CLEAR.
REQ-025 Deasserting enable during RUN SHALL NOT abort the integration; the block finishes, dumps, then goes to IDLE.
REQ-026 out_valid SHALL equal buffer not-empty; out_data/out_seq SHALL be stable while out_valid=1 and out_ready=0.
REQ-027 A simultaneous buffer write and read when full is not permitted (a DUMP write requires not-full); a simultaneous write and read when not full or empty SHALL leave occupancy unchanged.
REQ-028 The sample counter SHALL be ACC_LEN_WIDTH bits and never wrap within an integration.

Reset
REQ-029 While rst=0: state=IDLE, count=0, len_q=1, seq=0, buffer empty.
REQ-030 While rst=0: out_valid=0, in_ready=0, acc_en=0, acc_clr=0.
REQ-031 Reset mid-integration SHALL discard partial and buffered results; the first post-reset cycle issues no acc_en.

Structure
REQ-032 FSM state encoding and the seq width (16) SHALL live in shared package acc_pkg.
REQ-033 The output buffer SHALL be sub-module sync_fifo, with parameters WIDTH=INPUT_DATA_WIDTH+16 and DEPTH=FIFO_DEPTH, and ports full/empty.
REQ-034 All outputs except out_data/out_seq/out_valid SHALL be decoded from registered state.

Verification
REQ-035 Test: acc_len=4, enable=1, samples 1,2,3,4 continuous, out_ready=1. Expected: out_data=10, out_seq=0; acc_clr pulse before the first sample.
REQ-036 Test: acc_len=0, samples 5,7. Expected: two outputs, 5 (seq 0) and 7 (seq 1); each integration lasts 3 cycles.
REQ-037 Test: out_ready=0, acc_len=1, FIFO_DEPTH=4, 6 samples. Expected: 4 words buffered, FSM held in DUMP, in_ready=0; then release out_ready. Expected: all 6 values in order, none lost.
REQ-038 Test: change acc_len 3 to 2 after the first accepted sample. Expected: the current result sums 3 samples; the next sums 2.
REQ-039 Test: enable=0 after 2 of 4 samples. Expected: the integration completes after 4 samples, one output, then IDLE with in_ready=0.
REQ-040 Test: rst=0 asserted mid-RUN with 2 words buffered. Expected: out_valid=0 immediately; after release, the next output has seq=0.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared definitions for the accumulate-and-dump controller: FSM encoding and
// sequence-number width.
package acc_pkg;

  localparam int SEQ_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DUMP  = 2'd3
  } state_t;

endpackage : acc_pkg

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational read port: rd_data always shows the
// head entry, so it stays stable until the entry is popped.
module sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign full    = (r_count == DEPTH_C);
  assign empty   = (r_count == '0);
  assign w_wr    = wr_en && !full;
  assign w_rd    = rd_en && !empty;
  assign rd_data = r_mem[r_rd_ptr];

  // NOTE: storage has no reset; validity is tracked by r_count alone, so the
  // array can map onto plain RAM/flops without a reset tree.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : sync_fifo

// File: rtl/acc_dump_ctrl.sv
// Gates and clears an external accumulator, counts samples per integration and
// dumps each {result, seq} into an output FIFO.
module acc_dump_ctrl
  import acc_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH = 32,
  parameter int ACC_LEN_WIDTH    = 16,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [ACC_LEN_WIDTH-1:0]    acc_len,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        acc_en,
  output logic                        acc_clr,
  input  logic [INPUT_DATA_WIDTH-1:0] acc_data,
  output logic [INPUT_DATA_WIDTH-1:0] out_data,
  output logic [SEQ_W-1:0]            out_seq,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int FW = INPUT_DATA_WIDTH + SEQ_W;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [ACC_LEN_WIDTH-1:0] r_count;
  logic [ACC_LEN_WIDTH-1:0] r_len_q;
  logic [SEQ_W-1:0]         r_seq;

  logic                     w_accept;
  logic                     w_last;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_fifo_wr;
  logic [ACC_LEN_WIDTH-1:0] w_len_eff;
  logic [FW-1:0]            w_fifo_rd_data;

  assign w_len_eff = (acc_len == '0) ? ACC_LEN_WIDTH'(1) : acc_len;
  assign w_accept  = (r_state == ST_RUN) && in_valid;
  // r_count < r_len_q while running, so the increment cannot wrap.
  assign w_last    = w_accept && ((r_count + ACC_LEN_WIDTH'(1)) == r_len_q);
  assign w_fifo_wr = (r_state == ST_DUMP) && !w_full;

  assign in_ready  = (r_state == ST_RUN);
  assign acc_clr   = (r_state == ST_CLEAR);
  assign acc_en    = (r_state == ST_CLEAR) || w_accept;

  // NOTE: next state gets a default before the case so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (enable) w_state_nxt = ST_CLEAR;
      ST_CLEAR: w_state_nxt = ST_RUN;
      ST_RUN:   if (w_last) w_state_nxt = ST_DUMP;
      ST_DUMP:  if (!w_full) w_state_nxt = enable ? ST_CLEAR : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_len_q <= ACC_LEN_WIDTH'(1);
      r_seq   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_CLEAR: begin
          r_count <= '0;
          r_len_q <= w_len_eff;
        end
        ST_RUN:  if (w_accept) r_count <= r_count + ACC_LEN_WIDTH'(1);
        ST_DUMP: if (w_fifo_wr) r_seq <= r_seq + SEQ_W'(1);
        default: ;
      endcase
    end
  end

  // acc_data is sampled in DUMP, one cycle after the last accepted sample,
  // which is when the accumulator's registered sum is final.
  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_fifo_wr),
    .wr_data ({acc_data, r_seq}),
    .rd_en   (out_ready),
    .rd_data (w_fifo_rd_data),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign out_valid = !w_empty;
  assign out_data  = w_fifo_rd_data[FW-1:SEQ_W];
  assign out_seq   = w_fifo_rd_data[SEQ_W-1:0];

endmodule : acc_dump_ctrl

// File: tb/tb_acc_dump_ctrl.sv
// Scoreboard bench for acc_dump_ctrl: tests push expected {data, seq} words,
// a negedge monitor pops and compares whenever an output word is consumed.
module tb_acc_dump_ctrl;

  localparam int DW = 32;
  localparam int LW = 16;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic [LW-1:0] acc_len = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          acc_en;
  logic          acc_clr;
  logic [DW-1:0] acc_data;
  logic [DW-1:0] out_data;
  logic [15:0]   out_seq;
  logic          out_valid;
  logic          out_ready = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int clr_cnt = 0;
  logic [15:0] exp_seq = '0;
  logic [DW+15:0] sb [$];
  int pop_t [$];

  always #5 clk = ~clk;

  acc_dump_ctrl #(
    .INPUT_DATA_WIDTH (DW),
    .ACC_LEN_WIDTH    (LW),
    .FIFO_DEPTH       (FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .acc_len   (acc_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .acc_en    (acc_en),
    .acc_clr   (acc_clr),
    .acc_data  (acc_data),
    .out_data  (out_data),
    .out_seq   (out_seq),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Accumulator stage model driven by the DUT's gate and clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        acc_data <= '0;
    else if (acc_en) acc_data <= acc_clr ? '0 : acc_data + in_data;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every word actually consumed against the scoreboard head.
  always @(negedge clk) begin
    if (acc_en && acc_clr) clr_cnt++;
    if (rst && out_valid && out_ready) begin
      pop_t.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexpected_output", {16'd0, out_data, out_seq}, 64'hDEAD);
      end else begin
        check("output_word", {16'd0, out_data, out_seq}, {16'd0, sb.pop_front()});
      end
    end
  end

  task automatic expect_word(input logic [DW-1:0] d);
    sb.push_back({d, exp_seq});
    exp_seq = exp_seq + 16'd1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds a sample until accepted; returns just after the accepting edge.
  task automatic send(input logic [DW-1:0] v);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = v;
    while (!in_ready && n < 200) begin
      step(1);
      n++;
    end
    if (n >= 200) check("send_timeout", 64'(n), 64'd0);
    step(1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      step(1);
      n++;
    end
    check("drain_remaining", 64'(sb.size()), 64'd0);
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b0;
    #1;
    check({tag, "_rst_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_rst_in_ready"},  64'(in_ready),  64'd0);
    check({tag, "_rst_acc_en"},    64'({acc_en, acc_clr}), 64'd0);
    sb.delete();
    exp_seq = '0;
    step(2);
    rst = 1'b1;
    #1;
    check({tag, "_post_rst_acc_en"}, 64'(acc_en), 64'd0);
    step(1);
  endtask

  initial begin
    // Power-on reset, idle defaults.
    step(1);
    apply_reset("init");

    // Test 1: acc_len=4, samples 1..4 -> 10 seq 0, with a clear beforehand.
    out_ready = 1'b1;
    acc_len   = 16'd4;
    clr_cnt   = 0;
    enable    = 1'b1;
    expect_word(32'd10);
    send(32'd1);
    check("t1_clr_before_first", 64'(clr_cnt), 64'd1);
    send(32'd2);
    send(32'd3);
    send(32'd4);
    enable   = 1'b0;
    in_valid = 1'b0;
    drain();

    // Test 2: acc_len=0 acts as 1; two 3-cycle integrations.
    apply_reset("t2");
    out_ready = 1'b1;
    acc_len   = 16'd0;
    pop_t.delete();
    enable    = 1'b1;
    expect_word(32'd5);
    expect_word(32'd7);
    send(32'd5);
    send(32'd7);
    enable   = 1'b0;
    in_valid = 1'b0;
    drain();
    check("t2_pop_count", 64'(pop_t.size()), 64'd2);
    if (pop_t.size() == 2) check("t2_period", 64'(pop_t[1] - pop_t[0]), 64'd3);

    // Test 3: back-pressure with a full buffer, then release.
    apply_reset("t3");
    out_ready = 1'b0;
    acc_len   = 16'd1;
    enable    = 1'b1;
    for (int i = 1; i <= 6; i++) expect_word(32'(i * 11));
    for (int i = 1; i <= 5; i++) send(32'(i * 11));
    in_valid = 1'b0;
    step(8);
    check("t3_stall_in_ready", 64'(in_ready), 64'd0);
    check("t3_stall_acc_en", 64'(acc_en), 64'd0);
    check("t3_stall_out_valid", 64'(out_valid), 64'd1);
    check("t3_stall_head", {16'd0, out_data, out_seq}, {16'd0, 32'd11, 16'd0});
    check("t3_sb_untouched", 64'(sb.size()), 64'd6);
    out_ready = 1'b1;
    send(32'd66);
    enable   = 1'b0;
    in_valid = 1'b0;
    drain();

    // Test 4: acc_len change mid-run applies at the next clear.
    apply_reset("t4");
    out_ready = 1'b1;
    acc_len   = 16'd3;
    enable    = 1'b1;
    expect_word(32'd7);
    expect_word(32'd24);
    send(32'd1);
    acc_len = 16'd2;
    send(32'd2);
    send(32'd4);
    send(32'd8);
    send(32'd16);
    enable   = 1'b0;
    in_valid = 1'b0;
    drain();

    // Test 5: enable dropped mid-integration still completes it.
    apply_reset("t5");
    out_ready = 1'b1;
    acc_len   = 16'd4;
    enable    = 1'b1;
    expect_word(32'd100);
    send(32'd10);
    send(32'd20);
    enable = 1'b0;
    send(32'd30);
    send(32'd40);
    in_valid = 1'b1;
    in_data  = 32'd999;
    drain();
    step(4);
    check("t5_idle_in_ready", 64'(in_ready), 64'd0);
    check("t5_idle_acc_en", 64'(acc_en), 64'd0);
    in_valid = 1'b0;

    // Test 6: reset mid-run with two buffered words discards them.
    apply_reset("t6a");
    out_ready = 1'b0;
    acc_len   = 16'd1;
    enable    = 1'b1;
    send(32'd10);
    send(32'd20);
    step(2);
    check("t6_buffered_valid", 64'(out_valid), 64'd1);
    check("t6_running", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    apply_reset("t6");
    out_ready = 1'b1;
    expect_word(32'd9);
    send(32'd9);
    enable   = 1'b0;
    in_valid = 1'b0;
    drain();

    step(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_acc_dump_ctrl
